// File: rtl/fire_scheduler_if.sv
// Fire-request side and bullet-engine side of the shared fire scheduler.
// The master drives requests and pool state; the slave (scheduler) drives launches.
interface fire_scheduler_if #(
    parameter int NUM_REQ     = 2,
    parameter int MAX_BULLETS = 8,
    parameter int AW          = 2
);
    logic                     game_over;
    logic [NUM_REQ-1:0]       req;
    logic [2*NUM_REQ-1:0]     req_dir;
    logic [10*NUM_REQ-1:0]    req_x;
    logic [10*NUM_REQ-1:0]    req_y;
    logic [MAX_BULLETS-1:0]   active_mask;
    logic                     fire;
    logic [1:0]               bullet_dir;
    logic [9:0]               init_x;
    logic [9:0]               init_y;
    logic [NUM_REQ-1:0]       grant;
    logic [AW*NUM_REQ-1:0]    ammo;
    logic                     busy;

    modport master (
        output game_over, req, req_dir, req_x, req_y, active_mask,
        input  fire, bullet_dir, init_x, init_y, grant, ammo, busy
    );

    modport slave (
        input  game_over, req, req_dir, req_x, req_y, active_mask,
        output fire, bullet_dir, init_x, init_y, grant, ammo, busy
    );
endinterface

// File: rtl/fire_scheduler.sv
// Shares one bullet engine among NUM_REQ requesters: edge-detected requests,
// round-robin arbitration, per-requester cooldown and a reloading ammo magazine.
//
// state  | meaning
// IDLE   | waiting for a pending request and a free pool slot
// ISSUE  | one-cycle fire strobe for the registered winner
// SETTLE | lets active_mask pick up the new bullet before re-arbitrating
module fire_scheduler #(
    parameter int NUM_REQ       = 2,
    parameter int MAX_BULLETS   = 8,
    parameter int MAX_AMMO      = 3,
    parameter int COOLDOWN      = 20,
    parameter int RELOAD_CYCLES = 64
) (
    input  logic            clk,
    input  logic            reset,
    fire_scheduler_if.slave bus
);
    localparam int AW = $clog2(MAX_AMMO + 1);
    localparam int CW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
    localparam int RW = (RELOAD_CYCLES > 1) ? $clog2(RELOAD_CYCLES) : 1;
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, SETTLE} state_t;

    state_t             state, state_d;
    logic [PW-1:0]      win, win_d, arb_win, rr_ptr;
    logic               arb_found, load;
    logic [NUM_REQ-1:0] req_prev, pending, pend_d, shot, tc;
    logic [AW-1:0]      ammo_q [NUM_REQ];
    logic [CW-1:0]      cd_q   [NUM_REQ];
    logic [RW-1:0]      rl_q   [NUM_REQ];
    logic [1:0]         dir_q, sel_dir;
    logic [9:0]         x_q, y_q, sel_x, sel_y;

    // First pending index at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        arb_found = 1'b0;
        arb_win   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!arb_found && pending[i] && (i == (int'(rr_ptr) + k) % NUM_REQ)) begin
                    arb_found = 1'b1;
                    arb_win   = PW'(i);
                end
            end
        end
        sel_dir = '0;
        sel_x   = '0;
        sel_y   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_win == PW'(i)) begin
                sel_dir = bus.req_dir[2*i +: 2];
                sel_x   = bus.req_x[10*i +: 10];
                sel_y   = bus.req_y[10*i +: 10];
            end
        end
    end

    always_comb begin
        state_d = state;
        win_d   = win;
        load    = 1'b0;
        case (state)
            IDLE: begin
                if (!bus.game_over && arb_found && !(&bus.active_mask)) begin
                    state_d = ISSUE;
                    win_d   = arb_win;
                    load    = 1'b1;
                end
            end
            ISSUE:   state_d = SETTLE;
            SETTLE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        shot   = '0;
        tc     = '0;
        pend_d = pending;
        for (int i = 0; i < NUM_REQ; i++) begin
            shot[i] = (state == ISSUE) && (win == PW'(i));
            tc[i]   = !bus.game_over && (ammo_q[i] != AW'(MAX_AMMO))
                      && (rl_q[i] == RW'(RELOAD_CYCLES - 1));
            if (bus.game_over)
                pend_d[i] = 1'b0;
            else if (bus.req[i] && !req_prev[i] && (ammo_q[i] != '0) && (cd_q[i] == '0))
                pend_d[i] = 1'b1;
            if (shot[i])
                pend_d[i] = 1'b0;
        end
    end

    always_comb begin
        bus.fire  = (state == ISSUE);
        bus.busy  = (state != IDLE);
        bus.grant = shot;
        bus.ammo  = '0;
        for (int i = 0; i < NUM_REQ; i++)
            bus.ammo[AW*i +: AW] = ammo_q[i];
    end

    assign bus.bullet_dir = dir_q;
    assign bus.init_x     = x_q;
    assign bus.init_y     = y_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            win      <= '0;
            rr_ptr   <= '0;
            req_prev <= '0;
            pending  <= '0;
            dir_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                ammo_q[i] <= AW'(MAX_AMMO);
                cd_q[i]   <= '0;
                rl_q[i]   <= '0;
            end
        end else begin
            state    <= state_d;
            win      <= win_d;
            req_prev <= bus.req;
            pending  <= pend_d;
            if (load) begin
                dir_q <= sel_dir;
                x_q   <= sel_x;
                y_q   <= sel_y;
            end
            if (state == ISSUE)
                rr_ptr <= (win == PW'(NUM_REQ - 1)) ? '0 : win + PW'(1);
            // A shot restarts the reload delay, so reload is timed from the last shot.
            for (int i = 0; i < NUM_REQ; i++) begin
                if (shot[i] && !tc[i] && (ammo_q[i] != '0))
                    ammo_q[i] <= ammo_q[i] - AW'(1);
                else if (tc[i] && !shot[i])
                    ammo_q[i] <= ammo_q[i] + AW'(1);

                if (shot[i] || tc[i] || (ammo_q[i] == AW'(MAX_AMMO)))
                    rl_q[i] <= '0;
                else if (!bus.game_over)
                    rl_q[i] <= rl_q[i] + RW'(1);

                if (shot[i])
                    cd_q[i] <= CW'(COOLDOWN);
                else if (!bus.game_over && (cd_q[i] != '0))
                    cd_q[i] <= cd_q[i] - CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_fire_scheduler.sv
// Directed bench for fire_scheduler with COOLDOWN=4, RELOAD_CYCLES=8, MAX_AMMO=3, NUM_REQ=2.
// Each test starts from reset; "@n" in comments means 1 time unit after clock edge n.
module tb_fire_scheduler;
    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    int   seen;

    always #5 clk = ~clk;

    fire_scheduler_if #(.NUM_REQ(2), .MAX_BULLETS(8), .AW(2)) bus ();

    fire_scheduler #(
        .NUM_REQ(2), .MAX_BULLETS(8), .MAX_AMMO(3), .COOLDOWN(4), .RELOAD_CYCLES(8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        reset           = 1'b1;
        bus.game_over   = 1'b0;
        bus.req         = '0;
        bus.req_dir     = '0;
        bus.req_x       = '0;
        bus.req_y       = '0;
        bus.active_mask = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.fire !== 1'b0) begin errors++; $display("FAIL reset_fire got=%b exp=0", bus.fire); end
        checks++; if (bus.grant !== 2'b00) begin errors++; $display("FAIL reset_grant got=%b exp=00", bus.grant); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.ammo !== 4'b1111) begin errors++; $display("FAIL reset_ammo got=%b exp=1111", bus.ammo); end
        checks++; if ({bus.bullet_dir, bus.init_x, bus.init_y} !== 22'd0) begin
            errors++; $display("FAIL reset_outputs got=%h exp=0", {bus.bullet_dir, bus.init_x, bus.init_y}); end
    endtask

    task automatic test_single_shot();
        do_reset();
        bus.req_dir = 4'b0011;
        bus.req_x   = {10'd0, 10'd64};
        bus.req_y   = {10'd0, 10'd96};
        bus.req     = 2'b01;
        tick();  // @0 edge sampled
        checks++; if (bus.fire !== 1'b0) begin errors++; $display("FAIL single_early got=%b exp=0", bus.fire); end
        tick();  // @1
        checks++; if (bus.fire !== 1'b1 || bus.grant !== 2'b01) begin
            errors++; $display("FAIL single_fire got fire=%b grant=%b exp fire=1 grant=01", bus.fire, bus.grant); end
        checks++; if (bus.bullet_dir !== 2'b11 || bus.init_x !== 10'd64 || bus.init_y !== 10'd96) begin
            errors++; $display("FAIL single_data got %b/%0d/%0d exp 11/64/96", bus.bullet_dir, bus.init_x, bus.init_y); end
        tick();  // @2
        checks++; if (bus.fire !== 1'b0 || bus.ammo[1:0] !== 2'd2) begin
            errors++; $display("FAIL single_after got fire=%b ammo0=%0d exp fire=0 ammo0=2", bus.fire, bus.ammo[1:0]); end
        seen = 0;
        for (int i = 0; i < 8; i++) begin tick(); if (bus.fire === 1'b1) seen++; end  // @10, req held
        checks++; if (seen != 0) begin errors++; $display("FAIL single_hold got fires=%0d exp 0", seen); end
        bus.req = 2'b00;
        tick();  // @11
        bus.req_dir = 4'b0111;
        bus.req_x   = {10'd200, 10'd64};
        bus.req_y   = {10'd100, 10'd96};
        bus.req     = 2'b11;
        tick();  // @12 both pending, rr_ptr=1
        bus.req = 2'b00;
        tick();  // @13
        checks++; if (bus.grant !== 2'b10 || bus.init_x !== 10'd200) begin
            errors++; $display("FAIL rr_after_single got grant=%b x=%0d exp grant=10 x=200", bus.grant, bus.init_x); end
        tick_n(3);  // @16
        checks++; if (bus.grant !== 2'b01 || bus.init_x !== 10'd64) begin
            errors++; $display("FAIL rr_second got grant=%b x=%0d exp grant=01 x=64", bus.grant, bus.init_x); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.req_dir = {2'b01, 2'b00};
        bus.req_x   = {10'd30, 10'd10};
        bus.req_y   = {10'd40, 10'd20};
        bus.req     = 2'b11;
        tick();  // @0
        bus.req = 2'b00;
        tick();  // @1
        checks++; if (bus.grant !== 2'b01 || bus.init_x !== 10'd10 || bus.init_y !== 10'd20) begin
            errors++; $display("FAIL b2b_first got grant=%b x=%0d y=%0d exp 01/10/20", bus.grant, bus.init_x, bus.init_y); end
        tick();  // @2 SETTLE
        checks++; if (bus.fire !== 1'b0 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL b2b_settle got fire=%b busy=%b exp 0/1", bus.fire, bus.busy); end
        tick();  // @3 IDLE
        checks++; if (bus.fire !== 1'b0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL b2b_idle got fire=%b busy=%b exp 0/0", bus.fire, bus.busy); end
        tick();  // @4
        checks++; if (bus.grant !== 2'b10 || bus.bullet_dir !== 2'b01 || bus.init_x !== 10'd30 || bus.init_y !== 10'd40) begin
            errors++; $display("FAIL b2b_second got grant=%b dir=%b x=%0d y=%0d exp 10/01/30/40",
                               bus.grant, bus.bullet_dir, bus.init_x, bus.init_y); end
        tick();  // @5
        checks++; if (bus.ammo !== 4'b1010) begin errors++; $display("FAIL b2b_ammo got=%b exp=1010", bus.ammo); end
        tick_n(4);  // @9
        bus.req = 2'b11;
        tick();  // @10
        bus.req = 2'b00;
        tick();  // @11
        checks++; if (bus.grant !== 2'b01) begin errors++; $display("FAIL b2b_rr_wrap got grant=%b exp=01", bus.grant); end
    endtask

    task automatic test_cooldown_ammo();
        do_reset();
        bus.req = 2'b01;
        tick();  // @0
        bus.req = 2'b00;
        tick();  // @1
        checks++; if (bus.fire !== 1'b1) begin errors++; $display("FAIL cd_shot1 got=%b exp=1", bus.fire); end
        tick();  // @2
        checks++; if (bus.ammo[1:0] !== 2'd2) begin errors++; $display("FAIL cd_ammo_2 got=%0d exp=2", bus.ammo[1:0]); end
        tick();  // @3
        bus.req = 2'b01;  // re-press inside cooldown
        tick();  // @4
        bus.req = 2'b00;
        seen = 0;
        if (bus.fire === 1'b1) seen++;
        tick(); if (bus.fire === 1'b1) seen++;  // @5
        tick(); if (bus.fire === 1'b1) seen++;  // @6
        checks++; if (seen != 0) begin errors++; $display("FAIL cd_blocked got fires=%0d exp 0", seen); end
        bus.req = 2'b01;
        tick();  // @7
        bus.req = 2'b00;
        tick();  // @8
        checks++; if (bus.fire !== 1'b1) begin errors++; $display("FAIL cd_shot2 got=%b exp=1", bus.fire); end
        tick();  // @9
        checks++; if (bus.ammo[1:0] !== 2'd1) begin errors++; $display("FAIL cd_ammo_1 got=%0d exp=1", bus.ammo[1:0]); end
        tick_n(4);  // @13
        bus.req = 2'b01;
        tick();  // @14
        bus.req = 2'b00;
        tick();  // @15
        checks++; if (bus.fire !== 1'b1) begin errors++; $display("FAIL cd_shot3 got=%b exp=1", bus.fire); end
        tick();  // @16
        checks++; if (bus.ammo[1:0] !== 2'd0) begin errors++; $display("FAIL cd_ammo_0 got=%0d exp=0", bus.ammo[1:0]); end
        tick_n(4);  // @20
        bus.req = 2'b01;  // empty magazine
        tick();  // @21
        bus.req = 2'b00;
        seen = 0;
        if (bus.fire === 1'b1) seen++;
        tick(); if (bus.fire === 1'b1) seen++;  // @22
        tick(); if (bus.fire === 1'b1) seen++;  // @23
        checks++; if (seen != 0) begin errors++; $display("FAIL cd_empty_press got fires=%0d exp 0", seen); end
        checks++; if (bus.ammo[1:0] !== 2'd0) begin errors++; $display("FAIL cd_pre_reload got=%0d exp=0", bus.ammo[1:0]); end
        tick();  // @24
        checks++; if (bus.ammo[1:0] !== 2'd1) begin errors++; $display("FAIL cd_reload got=%0d exp=1", bus.ammo[1:0]); end
    endtask

    task automatic test_pool_full();
        do_reset();
        bus.active_mask = 8'hFF;
        bus.req_dir     = {2'b10, 2'b00};
        bus.req_x       = {10'd300, 10'd0};
        bus.req_y       = {10'd1000, 10'd0};
        bus.req         = 2'b10;
        tick();  // @0
        bus.req = 2'b00;
        seen = 0;
        for (int i = 0; i < 3; i++) begin tick(); if (bus.fire === 1'b1) seen++; end  // @3
        checks++; if (seen != 0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL pool_full_hold got fires=%0d busy=%b exp 0/0", seen, bus.busy); end
        bus.active_mask = 8'hF7;
        tick();  // @4
        checks++; if (bus.fire !== 1'b1 || bus.grant !== 2'b10) begin
            errors++; $display("FAIL pool_release got fire=%b grant=%b exp 1/10", bus.fire, bus.grant); end
        checks++; if (bus.bullet_dir !== 2'b10 || bus.init_x !== 10'd300 || bus.init_y !== 10'd1000) begin
            errors++; $display("FAIL pool_data got %b/%0d/%0d exp 10/300/1000", bus.bullet_dir, bus.init_x, bus.init_y); end
        tick();  // @5
        checks++; if (bus.ammo[3:2] !== 2'd2) begin errors++; $display("FAIL pool_ammo1 got=%0d exp=2", bus.ammo[3:2]); end
    endtask

    task automatic test_game_over();
        do_reset();
        bus.req = 2'b01;
        tick();  // @0
        bus.req = 2'b00;
        tick();  // @1
        checks++; if (bus.fire !== 1'b1) begin errors++; $display("FAIL go_setup_fire got=%b exp=1", bus.fire); end
        tick_n(2);  // @3
        bus.req = 2'b10;
        tick();  // @4 req1 pending
        bus.req       = 2'b00;
        bus.game_over = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin tick(); if (bus.fire === 1'b1) seen++; end  // @14
        checks++; if (seen != 0) begin errors++; $display("FAIL go_no_fire got fires=%0d exp 0", seen); end
        checks++; if (bus.ammo[1:0] !== 2'd2) begin errors++; $display("FAIL go_ammo_frozen got=%0d exp=2", bus.ammo[1:0]); end
        bus.game_over = 1'b0;
        bus.req       = 2'b01;  // cooldown frozen at 2, so this press is dropped
        tick();  // @15
        bus.req = 2'b00;
        seen = 0;
        if (bus.fire === 1'b1) seen++;
        for (int i = 0; i < 3; i++) begin tick(); if (bus.fire === 1'b1) seen++; end  // @18
        checks++; if (seen != 0) begin errors++; $display("FAIL go_after_drop got fires=%0d exp 0", seen); end
        tick();  // @19
        checks++; if (bus.ammo[1:0] !== 2'd2) begin errors++; $display("FAIL go_resume_early got=%0d exp=2", bus.ammo[1:0]); end
        tick();  // @20
        checks++; if (bus.ammo[1:0] !== 2'd3) begin errors++; $display("FAIL go_resume got=%0d exp=3", bus.ammo[1:0]); end
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.req = 2'b01;
        tick();  // @0
        bus.req = 2'b00;
        tick_n(2);  // @2 ammo0=2
        bus.req = 2'b10;
        tick();  // @3
        bus.req = 2'b00;
        tick();  // @4
        checks++; if (bus.fire !== 1'b1) begin errors++; $display("FAIL ar_precondition got=%b exp=1", bus.fire); end
        #2 reset = 1'b1;
        #1;
        checks++; if (bus.fire !== 1'b0 || bus.grant !== 2'b00 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL ar_drop got fire=%b grant=%b busy=%b exp 0/00/0", bus.fire, bus.grant, bus.busy); end
        checks++; if (bus.ammo !== 4'b1111) begin errors++; $display("FAIL ar_ammo got=%b exp=1111", bus.ammo); end
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        test_reset();
        test_single_shot();
        test_back_to_back();
        test_cooldown_ammo();
        test_pool_full();
        test_game_over();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
